// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package modexp_pkg;

    localparam int unsigned WIDTH  = 512;
    localparam int unsigned ELEN_W = 10;

    // Main sequencer states; each op state issues one multiplier operation.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONV_IN  = 3'd1,
        LOAD     = 3'd2,
        SCAN     = 3'd3,
        SQR      = 3'd4,
        MUL      = 3'd5,
        CONV_OUT = 3'd6,
        DONE     = 3'd7
    } state_e;

    // Handshake phases of a single multiplier operation.
    typedef enum logic [1:0] {
        PREP = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2
    } phase_e;

    // True for every state in which a run is in progress.
    function automatic logic is_run_state(input state_e s);
        return !((s == IDLE) || (s == DONE));
    endfunction

endpackage : modexp_pkg

// File: rtl/modexp_mul_port.sv
// Multiplier port: owns operand registers and the PREP/GO/WAIT handshake.
// A one-cycle issue loads operands; cap_c pulses in the WAIT cycle that
// sees mul_done, carrying the truncated result.
module modexp_mul_port #(
    parameter int unsigned WIDTH = modexp_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_m,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_m,
    output logic             prep,
    output logic             mul_start,
    input  logic [WIDTH+1:0] mul_result,
    input  logic             mul_done,
    output logic             cap_c,
    output logic [WIDTH-1:0] cap_data_c
);

    import modexp_pkg::*;

    phase_e           phase_q, phase_d;
    logic             active_q, active_d;
    logic             prep_d;
    logic             start_d;
    logic [WIDTH-1:0] a_d, b_d, m_d;

    // The two guard bits above WIDTH are dropped on purpose.
    logic unused_mul_hi;
    assign unused_mul_hi = ^mul_result[WIDTH+1:WIDTH];

    // Result capture is only honoured while waiting on an active op.
    assign cap_c      = active_q && (phase_q == WAIT) && mul_done;
    assign cap_data_c = mul_result[WIDTH-1:0];

    // Next phase, strobes and operand loads.
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        prep_d   = 1'b0;
        start_d  = 1'b0;
        a_d      = mul_a;
        b_d      = mul_b;
        m_d      = mul_m;
        if (issue) begin
            active_d = 1'b1;
            phase_d  = PREP;
            prep_d   = 1'b1;
            a_d      = op_a;
            b_d      = op_b;
            m_d      = op_m;
        end else if (active_q) begin
            case (phase_q)
                PREP: begin
                    phase_d = GO;
                    start_d = 1'b1;
                end
                GO: phase_d = WAIT;
                WAIT: begin
                    if (mul_done) begin
                        active_d = 1'b0;
                        phase_d  = PREP;
                    end
                end
                default: phase_d = PREP;
            endcase
        end
    end

    // Phase and operand registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q   <= PREP;
            active_q  <= 1'b0;
            prep      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_m     <= '0;
        end else begin
            phase_q   <= phase_d;
            active_q  <= active_d;
            prep      <= prep_d;
            mul_start <= start_d;
            mul_a     <= a_d;
            mul_b     <= b_d;
            mul_m     <= m_d;
        end
    end

endmodule : modexp_mul_port

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer around a shared Montgomery
// multiplier. Computes x^e mod m with conversions into and out of the
// Montgomery domain.
module modexp_ctrl #(
    parameter int unsigned WIDTH  = modexp_pkg::WIDTH,
    parameter int unsigned ELEN_W = modexp_pkg::ELEN_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_r2,
    output logic [WIDTH-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              mul_resetn,
    output logic              mul_start,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    output logic [WIDTH-1:0]  mul_m,
    input  logic [WIDTH+1:0]  mul_result,
    input  logic              mul_done
);

    import modexp_pkg::*;

    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [ELEN_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  e_q, e_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  xt_q, xt_d;
    logic [WIDTH-1:0]  result_d;

    logic              issue;
    logic [WIDTH-1:0]  op_a, op_b, op_m;
    logic              prep;
    logic              cap_c;
    logic [WIDTH-1:0]  cap_data_c;

    // Multiplier is held clear during PREP and whenever the block is in reset.
    assign mul_resetn = resetn & ~prep;

    modexp_mul_port #(
        .WIDTH (WIDTH)
    ) u_port (
        .clk        (clk),
        .resetn     (resetn),
        .issue      (issue),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_m       (op_m),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .prep       (prep),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .cap_c      (cap_c),
        .cap_data_c (cap_data_c)
    );

    // Main sequencer: next state, datapath updates and op issue.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        e_d      = e_q;
        m_d      = m_q;
        r_d      = r_q;
        acc_d    = acc_q;
        xt_d     = xt_q;
        result_d = result;
        issue    = 1'b0;
        op_a     = acc_q;
        op_b     = acc_q;
        op_m     = m_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    e_d     = in_e;
                    m_d     = in_m;
                    r_d     = in_r;
                    idx_d   = (in_e_len > ELEN_W'(WIDTH)) ? ELEN_W'(WIDTH) : in_e_len;
                    issue   = 1'b1;
                    op_a    = in_x;
                    op_b    = in_r2;
                    op_m    = in_m;
                    state_d = CONV_IN;
                end
            end
            CONV_IN: begin
                if (cap_c) begin
                    xt_d    = cap_data_c;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_d   = r_q;
                state_d = SCAN;
            end
            SCAN: begin
                issue = 1'b1;
                if (idx_q == '0) begin
                    op_b    = WIDTH'(1);
                    state_d = CONV_OUT;
                end else begin
                    idx_d   = idx_q - ELEN_W'(1);
                    state_d = SQR;
                end
            end
            SQR: begin
                if (cap_c) begin
                    acc_d = cap_data_c;
                    if (e_q[idx_q[IDX_W-1:0]]) begin
                        // Chain straight into the multiply using the fresh square.
                        issue   = 1'b1;
                        op_a    = cap_data_c;
                        op_b    = xt_q;
                        state_d = MUL;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            MUL: begin
                if (cap_c) begin
                    acc_d   = cap_data_c;
                    state_d = SCAN;
                end
            end
            CONV_OUT: begin
                if (cap_c) begin
                    result_d = cap_data_c;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            e_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            xt_q    <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            e_q     <= e_d;
            m_q     <= m_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            xt_q    <= xt_d;
            result  <= result_d;
            done    <= (state_d == DONE);
            busy    <= is_run_state(state_d);
        end
    end

endmodule : modexp_ctrl
